// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared combinational ALU.
// Issue stage S1 drives the ALU, result stage S2 returns the result to its owner.
`ifndef DATA_WIDTH_GPR
`define DATA_WIDTH_GPR 32
`endif
`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 4
`endif

module alu_arbiter #(
   parameter int unsigned DATA_W = `DATA_WIDTH_GPR,
   parameter int unsigned OP_W   = `DATA_WIDTH_ALU_OP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              req0_valid,
   input  logic              req1_valid,
   output logic              req0_ready,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req0_in_0,
   input  logic [DATA_W-1:0] req0_in_1,
   input  logic [DATA_W-1:0] req1_in_0,
   input  logic [DATA_W-1:0] req1_in_1,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_in_0,
   output logic [DATA_W-1:0] alu_in_1,
   input  logic [DATA_W-1:0] alu_out,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   input  logic              rsp0_ready,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp0_data,
   output logic [DATA_W-1:0] rsp1_data
);

   logic              s1_v_q, s1_v_d;
   logic              s1_id_q, s1_id_d;
   logic [OP_W-1:0]   s1_op_q, s1_op_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic              s2_v_q, s2_v_d;
   logic              s2_id_q, s2_id_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic              last_q, last_d;

   logic drain, s2_free, s1_move, s1_free;
   logic elig0, elig1, grant0, grant1;

   // Response channel, with port-0 results hidden while a flush is in progress.
   always_comb begin
      rsp0_valid = s2_v_q & ~s2_id_q & ~flush;
      rsp1_valid = s2_v_q & s2_id_q;
      rsp0_data  = s2_data_q;
      rsp1_data  = s2_data_q;
      alu_op     = s1_v_q ? s1_op_q : '0;
      alu_in_0   = s1_v_q ? s1_a_q  : '0;
      alu_in_1   = s1_v_q ? s1_b_q  : '0;
   end

   // Pipeline advance and round-robin grant; last_q=1 lets port 0 win first.
   always_comb begin
      drain      = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
      s2_free    = ~s2_v_q | drain;
      s1_move    = s1_v_q & s2_free;
      s1_free    = ~s1_v_q | s1_move;
      elig0      = req0_valid & ~flush;
      elig1      = req1_valid;
      grant0     = elig0 & (~elig1 | last_q);
      grant1     = elig1 & (~elig0 | ~last_q);
      req0_ready = ~rst & s1_free & grant0;
      req1_ready = ~rst & s1_free & grant1;
   end

   // Next-state for both stages and the arbiter history.
   always_comb begin
      s1_v_d    = s1_v_q;
      s1_id_d   = s1_id_q;
      s1_op_d   = s1_op_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s2_v_d    = s2_v_q;
      s2_id_d   = s2_id_q;
      s2_data_d = s2_data_q;
      last_d    = last_q;

      if (s1_move) begin
         s2_v_d    = ~(flush & ~s1_id_q);
         s2_id_d   = s1_id_q;
         s2_data_d = alu_out;
      end else if (drain || (flush && !s2_id_q)) begin
         s2_v_d = 1'b0;
      end

      if (req0_ready) begin
         s1_v_d  = 1'b1;
         s1_id_d = 1'b0;
         s1_op_d = req0_op;
         s1_a_d  = req0_in_0;
         s1_b_d  = req0_in_1;
         last_d  = 1'b0;
      end else if (req1_ready) begin
         s1_v_d  = 1'b1;
         s1_id_d = 1'b1;
         s1_op_d = req1_op;
         s1_a_d  = req1_in_0;
         s1_b_d  = req1_in_1;
         last_d  = 1'b1;
      end else if (s1_move || (flush && !s1_id_q)) begin
         s1_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_id_q   <= 1'b0;
         s1_op_q   <= '0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s2_v_q    <= 1'b0;
         s2_id_q   <= 1'b0;
         s2_data_q <= '0;
         last_q    <= 1'b1;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_id_q   <= s1_id_d;
         s1_op_q   <= s1_op_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s2_v_q    <= s2_v_d;
         s2_id_q   <= s2_id_d;
         s2_data_q <= s2_data_d;
         last_q    <= last_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors and sequences, then random traffic
// checked by an in-order response scoreboard.
module tb_alu_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned OW = 4;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                          OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6;

   logic clk, rst, flush;
   logic req0_valid, req1_valid, req0_ready, req1_ready;
   logic [OW-1:0] req0_op, req1_op, alu_op;
   logic [DW-1:0] req0_in_0, req0_in_1, req1_in_0, req1_in_1;
   logic [DW-1:0] alu_in_0, alu_in_1, alu_out;
   logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [DW-1:0] rsp0_data, rsp1_data;

   alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_in_0(req0_in_0), .req0_in_1(req0_in_1),
      .req1_in_0(req1_in_0), .req1_in_1(req1_in_1),
      .alu_op(alu_op), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_out(alu_out),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp0_data(rsp0_data), .rsp1_data(rsp1_data)
   );

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   // Stand-in for the shared ALU.
   always_comb alu_out = alu_f(alu_op, alu_in_0, alu_in_1);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   typedef struct packed {
      logic        id;
      logic [31:0] data;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t tmp_q[$];
   rsp_t log_q[$];
   int   last_m = 1;
   bit   acc0, acc1;

   // Scoreboard: in-flight results in acceptance order, plus round-robin rule.
   always @(negedge clk) begin
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (rst) begin
         exp_q.delete();
         last_m = 1;
      end else begin
         chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
         if (req0_ready) chk("ready0_without_valid", 32'(req0_valid), 32'd1);
         if (req1_ready) chk("ready1_without_valid", 32'(req1_valid), 32'd1);
         if (flush) begin
            chk("flush_rsp0_gated", 32'(rsp0_valid), 32'd0);
            chk("flush_req0_blocked", 32'(req0_ready), 32'd0);
         end
         if (req0_valid && req1_valid && !flush && (req0_ready || req1_ready))
            chk("rr_grant_port", 32'(req1_ready), 32'(last_m == 0));
         if (rsp0_valid || rsp1_valid) begin
            chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
            chk("rsp_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("rsp_owner", 32'(rsp1_valid), 32'(exp_q[0].id));
               chk("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, exp_q[0].data);
               if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                  log_q.push_back({rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data});
                  void'(exp_q.pop_front());
               end
            end
         end
         if (flush) begin
            tmp_q.delete();
            foreach (exp_q[i]) if (exp_q[i].id) tmp_q.push_back(exp_q[i]);
            exp_q = tmp_q;
         end
         if (acc0) begin
            exp_q.push_back({1'b0, alu_f(req0_op, req0_in_0, req0_in_1)});
            last_m = 0;
         end
         if (acc1) begin
            exp_q.push_back({1'b1, alu_f(req1_op, req1_in_0, req1_in_1)});
            last_m = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = v; req0_op = op; req0_in_0 = a; req0_in_1 = b;
   endtask

   task automatic set_req1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req1_valid = v; req1_op = op; req1_in_0 = a; req1_in_1 = b;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[7];
   rsp_t bp_exp[4];

   initial begin
      int cnt0, cnt1;
      vecs[0] = '{OP_ADD, 32'd33,        32'd22,        32'd55};
      vecs[1] = '{OP_SUB, 32'd33,        32'd22,        32'd11};
      vecs[2] = '{OP_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE};
      vecs[3] = '{OP_SLL, 32'h5E2E_0AD6, 32'd6,         32'h8B82_B580};
      vecs[4] = '{OP_XOR, 32'h0000_FF00, 32'h0000_00DF, 32'h0000_FFDF};
      vecs[5] = '{OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
      vecs[6] = '{OP_SRL, 32'h8000_0000, 32'd4,         32'h0800_0000};
      bp_exp[0] = {1'b1, 32'd3};
      bp_exp[1] = {1'b0, 32'd30};
      bp_exp[2] = {1'b1, 32'd15};
      bp_exp[3] = {1'b0, 32'd300};

      // Reset held two cycles with both ports requesting.
      rst = 1'b1; flush = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req0(1'b1, OP_SUB, 32'd33, 32'd22);
      set_req1(1'b1, OP_SLL, 32'h5E2E_0AD6, 32'd6);
      tick();
      @(negedge clk);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_rsp1_data", rsp1_data, 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_in_0", alu_in_0, 32'd0);
      chk("rst_alu_in_1", alu_in_1, 32'd0);
      tick();
      rst = 1'b0;

      // Contention: grants alternate starting with port 0, one result per cycle.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("cont_req0_ready", 32'(req0_ready), 32'(k % 2 == 0));
         chk("cont_req1_ready", 32'(req1_ready), 32'(k % 2 == 1));
         if (k >= 2) begin
            chk("cont_rsp0_valid", 32'(rsp0_valid), 32'(k % 2 == 0));
            chk("cont_rsp1_valid", 32'(rsp1_valid), 32'(k % 2 == 1));
            chk("cont_rsp_data", (k % 2 == 0) ? rsp0_data : rsp1_data,
                (k % 2 == 0) ? 32'd11 : 32'h8B82_B580);
         end
         tick();
      end
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
      repeat (4) tick();

      // Single port-0 operations: ALU driven at E+1, response at E+2.
      for (int v = 0; v < 7; v++) begin
         set_req0(1'b1, vecs[v].op, vecs[v].a, vecs[v].b);
         @(negedge clk);
         chk("vec_req0_ready", 32'(req0_ready), 32'd1);
         tick();
         set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
         @(negedge clk);
         chk("vec_alu_op", 32'(alu_op), 32'(vecs[v].op));
         chk("vec_alu_in_0", alu_in_0, vecs[v].a);
         tick();
         @(negedge clk);
         chk("vec_rsp0_valid", 32'(rsp0_valid), 32'd1);
         chk("vec_rsp0_data", rsp0_data, vecs[v].exp);
         chk("vec_rsp1_valid", 32'(rsp1_valid), 32'd0);
         tick();
      end
      repeat (2) tick();

      // Backpressure on port 1 with both stages full.
      log_q.delete();
      rsp1_ready = 1'b0;
      set_req1(1'b1, OP_ADD, 32'd1, 32'd2);
      @(negedge clk);
      chk("bp_accept_a", 32'(req1_ready), 32'd1);
      tick();
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
      set_req0(1'b1, OP_ADD, 32'd10, 32'd20);
      @(negedge clk);
      chk("bp_accept_b", 32'(req0_ready), 32'd1);
      tick();
      set_req0(1'b1, OP_ADD, 32'd100, 32'd200);
      set_req1(1'b1, OP_ADD, 32'd7, 32'd8);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_hold_rsp1_valid", 32'(rsp1_valid), 32'd1);
         chk("bp_hold_rsp1_data", rsp1_data, 32'd3);
         chk("bp_hold_rsp0_valid", 32'(rsp0_valid), 32'd0);
         chk("bp_stall_req0", 32'(req0_ready), 32'd0);
         chk("bp_stall_req1", 32'(req1_ready), 32'd0);
         tick();
      end
      rsp1_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_req1", 32'(req1_ready), 32'd1);
      chk("bp_release_req0", 32'(req0_ready), 32'd0);
      tick();
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
      @(negedge clk);
      chk("bp_then_req0", 32'(req0_ready), 32'd1);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
      repeat (5) tick();
      chk("bp_rsp_count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < log_q.size()) chk("bp_rsp_order", 32'(log_q[i]), 32'(bp_exp[i]));

      // Flush: port-0 ADD in S2, port-1 XOR in S1.
      log_q.delete();
      set_req0(1'b1, OP_ADD, 32'd5, 32'd6);
      @(negedge clk);
      chk("fl_accept_add", 32'(req0_ready), 32'd1);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
      set_req1(1'b1, OP_XOR, 32'h0000_FF00, 32'h0000_00DF);
      @(negedge clk);
      chk("fl_accept_xor", 32'(req1_ready), 32'd1);
      tick();
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      chk("fl_rsp0_hidden", 32'(rsp0_valid), 32'd0);
      tick();
      flush = 1'b0;
      cnt0 = 0; cnt1 = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         cnt0 += int'(rsp0_valid);
         cnt1 += int'(rsp1_valid);
         tick();
      end
      chk("fl_rsp0_never", 32'(cnt0), 32'd0);
      chk("fl_rsp1_once", 32'(cnt1), 32'd1);
      chk("fl_log_count", 32'(log_q.size()), 32'd1);
      if (log_q.size() != 0) chk("fl_xor_result", 32'(log_q[0]), 32'({1'b1, 32'h0000_FFDF}));

      // Reset with both stages full, then immediate port-1 acceptance.
      log_q.delete();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      set_req0(1'b1, OP_ADD, 32'd1, 32'd1);
      tick();
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
      set_req1(1'b1, OP_ADD, 32'd2, 32'd2);
      tick();
      rst = 1'b1;
      set_req1(1'b1, OP_SUB, 32'd50, 32'd8);
      @(negedge clk);
      chk("mr_pipe_full", 32'(rsp0_valid), 32'd1);
      chk("mr_ready_in_rst", 32'(req1_ready), 32'd0);
      tick();
      rst = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(negedge clk);
      chk("mr_first_accept", 32'(req1_ready), 32'd1);
      chk("mr_rsp0_gone", 32'(rsp0_valid), 32'd0);
      chk("mr_rsp1_gone", 32'(rsp1_valid), 32'd0);
      tick();
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
      @(negedge clk);
      chk("mr_rsp0_still_gone", 32'(rsp0_valid), 32'd0);
      chk("mr_rsp1_still_gone", 32'(rsp1_valid), 32'd0);
      tick();
      @(negedge clk);
      chk("mr_new_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("mr_new_rsp1_data", rsp1_data, 32'd42);
      tick();
      repeat (3) tick();
      chk("mr_log_count", 32'(log_q.size()), 32'd1);

      // Random traffic; requesters hold their request until accepted.
      for (int i = 0; i < 1500; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         flush      = ($urandom_range(0, 19) == 0);
         rsp0_ready = ($urandom_range(0, 9) < 7);
         rsp1_ready = ($urandom_range(0, 9) < 7);
         if (!req0_valid || acc0)
            set_req0(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), $urandom, $urandom);
         if (!req1_valid || acc1)
            set_req1(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)), $urandom, $urandom);
         tick();
      end
      rst = 1'b0; flush = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      set_req0(1'b0, OP_ADD, 32'd0, 32'd0);
      set_req1(1'b0, OP_ADD, 32'd0, 32'd0);
      repeat (10) tick();
      chk("rand_all_delivered", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters: port 0 is the EX-stage issue path and port 1 is the auxiliary path (address generation / CSR arithmetic). The block arbitrates requests round-robin and registers the granted operation into an issue stage that drives the ALU inputs. It captures `alu_out` into a result stage and returns it to the owning requester over a valid/ready response channel. A flush input discards port-0 work in flight.

## Interface
- `DATA_W`, default `DATA_WIDTH_GPR` (32): operand and result width.
- `OP_W`, default `DATA_WIDTH_ALU_OP`: ALU opcode width; opcodes use the `ALU_OP_*` defines.
- `clk`  in  1  clock; everything samples on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  discards all port-0 entries in flight.
- `req0_valid`, `req1_valid`  in  1  request present on port n.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle on port n.
- `req0_op`, `req1_op`  in  OP_W  ALU opcode for port n.
- `req0_in_0`, `req0_in_1`, `req1_in_0`, `req1_in_1`  in  DATA_W  operands for port n.
- `alu_op`  out  OP_W  connects to `alu.alu_op`.
- `alu_in_0`, `alu_in_1`  out  DATA_W  connect to `alu.alu_in_0` and `alu.alu_in_1`.
- `alu_out`  in  DATA_W  combinational result from `alu`.
- `rsp0_valid`, `rsp1_valid`  out  1  result available for port n.
- `rsp0_ready`, `rsp1_ready`  in  1  port n consumes the result.
- `rsp0_data`, `rsp1_data`  out  DATA_W  result for port n.

## Operation
- **Pipeline stages.**
  - S1 (issue register): `s1_v`, `s1_id`, opcode and operands. `alu_op`, `alu_in_0` and `alu_in_1` come from the S1 registers and are forced to 0 when `s1_v`=0.
  - S2 (result register): `s2_v`, `s2_id`, `s2_data`.
- **Response outputs.**
  - `rsp0_valid` = `s2_v & (s2_id==0) & !flush`.
  - `rsp1_valid` = `s2_v & (s2_id==1)`.
  - `rsp0_data` and `rsp1_data` both equal `s2_data`.
- **Stage advance conditions.**
  - S2 drains when `rspN_valid & rspN_ready` for its owner.
  - `s2_free` = `!s2_v` | drain.
  - S1 moves into S2 when `s1_v & s2_free`; S2 then captures `alu_out` and `s1_id`.
  - `s1_free` = `!s1_v` | (S1 moving).
- **Arbitration.**
  - `last` flop holds the last granted port; reset value is 1, so port 0 wins the first contention.
  - Only port 0 valid: grant 0. Only port 1 valid: grant 1.
  - Both valid: grant `!last`.
  - While `flush`=1, port 0 is not eligible and port 1 may be granted alone.
- **Acceptance.** `reqN_ready` = `s1_free & grantN`. At most one ready is high per cycle. On acceptance, S1 loads that port's op and operands, `s1_id`=N, and `last`=N.
- **Flush.** At the edge where `flush`=1:
  - An S1 entry with `s1_id`==0 is invalidated.
  - An S2 entry with `s2_id`==0 is invalidated.
  - Port-1 entries are unaffected.
  - A port-1 entry in S1 still advances normally.
- **Reset.** All valid bits, ids and data registers clear to 0 and `last`=1. All outputs read 0: `req*_ready`, `rsp*_valid`, `rsp*_data`, `alu_op`, `alu_in_*`.
- **Ordering.** Responses are delivered in acceptance order; there is no reordering between ports.

## Timing
- Latency: a request accepted at edge E drives the ALU inputs during cycle E+1. Its result is visible on `rspN_valid` and `rspN_data` in cycle E+2.
- Throughput: one operation per cycle with no backpressure, including alternating ports.
- `req*_ready` is combinational from `req*_valid`, `flush`, the stage valids and `rsp*_ready`. Requesters must hold op and operands stable while valid and not ready.
- Response backpressure: while `rspN_ready`=0, S2 holds its value and S1 stalls behind it. With S1 also full, both `req*_ready` go to 0. No result is ever dropped or overwritten.
- A response handshake and an acceptance of a new request in the same cycle are both legal, and the pipeline stays full.
- `flush` together with `rsp0_ready`=1 in the same cycle: no port-0 handshake occurs because `rsp0_valid` is gated to 0.
- `rst` asserted mid-operation discards all in-flight work at that edge. The first acceptance is possible in the first cycle after `rst` deasserts.

## Test plan
- **Reset.** Hold `rst` 2 cycles with both ports valid → every output is 0. In the first cycle after release, `req0_ready`=1 and `req1_ready`=0.
- **Single op, port 0.** Port 0 issues `ALU_OP_ADD` with operands 33 and 22 → 2 cycles later `rsp0_valid`=1 and `rsp0_data`=55, and `rsp1_valid` stays 0.
- **Contention.**
  - Both ports request continuously: port 0 `ALU_OP_SUB` (33, 22), port 1 `ALU_OP_SLL` (0x5E2E0AD6, 6).
  - Grants alternate 0,1,0,1.
  - Responses alternate 11 on port 0 and 0x8B82B580 on port 1, one per cycle.
- **Backpressure.**
  - Hold `rsp1_ready`=0 with S2 owned by port 1 → S2 and S1 hold their contents and both `req*_ready`=0.
  - Release `rsp1_ready` → the held results are delivered in order with no loss or duplication.
- **Flush.** With a port-0 `ALU_OP_ADD` in S2 and a port-1 `ALU_OP_XOR` in S1, pulse `flush` for 1 cycle → the port-0 result is never presented. The port-1 XOR result 0x0000FFDF is presented one cycle later.
- **Mid-operation reset.** Assert `rst` while S1 and S2 are both full → no `rsp*_valid` appears afterwards, and a new port-1 request is accepted in the first cycle after `rst` deasserts.
